// File: rtl/mem_bus_pkg.sv
// Shared definitions for the /CE,/WE,/OE strobe bus: responder FSM states and
// the cycle-type codes reported at the end of every chip-enable cycle.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEL   = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_END   = 3'd4
  } bus_state_e;

  localparam logic [1:0] CYC_NONE  = 2'b00;
  localparam logic [1:0] CYC_READ  = 2'b01;
  localparam logic [1:0] CYC_WRITE = 2'b10;
  localparam logic [1:0] CYC_ERR   = 2'b11;

  // Error outranks write, write outranks read when one CE cycle saw several.
  function automatic logic [1:0] cycle_class(input logic err, input logic wr, input logic rd);
    if (err) return CYC_ERR;
    if (wr)  return CYC_WRITE;
    if (rd)  return CYC_READ;
    return CYC_NONE;
  endfunction

endpackage

// File: rtl/sram_array.sv
// Single-port synchronous RAM, one-clock read latency; the read register is
// resettable so the responder's DataOut comes out of reset at zero.
module sram_array #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)          rdata_q <= '0;
    else if (en && !we) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// sram_responder: on-FPGA stand-in for an async SRAM driven by /CE,/WE,/OE strobes.
// Defining TIMING_CHECK_EN adds a minimum strobe-width check (MIN_LOW clocks).
module sram_responder #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int MIN_LOW = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          CE,
  input  logic          WE,
  input  logic          OE,
  input  logic [AW-1:0] Addr,
  input  logic [DW-1:0] DataIn,
  output logic [DW-1:0] DataOut,
  output logic          DataOE,
  output logic          CycleDone,
  output logic [1:0]    CycleType,
  output logic          Error
);
  import mem_bus_pkg::*;

  logic          ce_q, we_q, oe_q;
  logic [AW-1:0] addr_q, addr_prev_q;
  logic [DW-1:0] din_q, din_prev_q;
  bus_state_e    state_q, state_d;
  logic          cyc_rd_q, cyc_rd_d, cyc_wr_q, cyc_wr_d, cyc_err_q, cyc_err_d;
  logic [1:0]    cycle_type_q, cycle_type_d;
  logic          error_q, error_d;
  logic          conflict, addr_moved, oe_in_write, short_strobe, err_now;
  logic          write_end, ram_we, ram_en, cyc_clear;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata;

  // The _prev copies hold the address/data seen the clock before a strobe rises.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ce_q        <= 1'b1;
      we_q        <= 1'b1;
      oe_q        <= 1'b1;
      addr_q      <= '0;
      addr_prev_q <= '0;
      din_q       <= '0;
      din_prev_q  <= '0;
    end else begin
      ce_q        <= CE;
      we_q        <= WE;
      oe_q        <= OE;
      addr_q      <= Addr;
      addr_prev_q <= addr_q;
      din_q       <= DataIn;
      din_prev_q  <= din_q;
    end
  end

`ifdef TIMING_CHECK_EN
  localparam int CNT_W = $clog2(MIN_LOW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_LOW_C = CNT_W'(MIN_LOW);

  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
  logic             strobe_on;

  always_comb begin
    strobe_on = !ce_q && (!we_q || !oe_q);
    low_cnt_d = '0;
    if (strobe_on) low_cnt_d = (low_cnt_q == CNT_MAX) ? low_cnt_q : low_cnt_q + 1'b1;
    short_strobe = !strobe_on && (low_cnt_q != '0) && (low_cnt_q < MIN_LOW_C);
  end

  always_ff @(posedge Clk) begin
    if (Reset) low_cnt_q <= '0;
    else       low_cnt_q <= low_cnt_d;
  end
`else
  logic unused_min_low;
  assign unused_min_low = (MIN_LOW > 0);
  assign short_strobe   = 1'b0;
`endif

  always_comb begin
    conflict    = !ce_q && !we_q && !oe_q;
    addr_moved  = !ce_q && (!we_q || !oe_q) && (addr_q != addr_prev_q);
    oe_in_write = (state_q == S_WRITE) && !oe_q;
    err_now     = conflict || addr_moved || oe_in_write || short_strobe;
    write_end   = (state_q == S_WRITE) && (we_q || ce_q);
    ram_we      = write_end && !short_strobe && !Reset;
    ram_en      = (state_q == S_READ);
    ram_addr    = ram_we ? addr_prev_q : addr_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!ce_q) state_d = S_SEL;
      S_SEL: begin
        if (ce_q)       state_d = S_END;
        else if (!we_q) state_d = S_WRITE;
        else if (!oe_q) state_d = S_READ;
      end
      S_READ: begin
        if (ce_q)       state_d = S_END;
        else if (!we_q) state_d = S_WRITE;
        else if (oe_q)  state_d = S_SEL;
      end
      S_WRITE: begin
        if (ce_q)       state_d = S_END;
        else if (we_q)  state_d = S_SEL;
      end
      S_END:   state_d = ce_q ? S_IDLE : S_SEL;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-cycle history is collected from selection until the END pulse.
  always_comb begin
    cyc_clear    = (state_q == S_IDLE) || (state_q == S_END);
    cyc_rd_d     = (!cyc_clear && cyc_rd_q) || (state_q == S_READ);
    cyc_wr_d     = (!cyc_clear && cyc_wr_q) || (state_q == S_WRITE);
    cyc_err_d    = (!cyc_clear && cyc_err_q) || err_now;
    error_d      = error_q || err_now;
    cycle_type_d = cycle_type_q;
    if (state_d == S_END) cycle_type_d = cycle_class(cyc_err_d, cyc_wr_d, cyc_rd_d);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      cyc_rd_q     <= 1'b0;
      cyc_wr_q     <= 1'b0;
      cyc_err_q    <= 1'b0;
      cycle_type_q <= CYC_NONE;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_rd_q     <= cyc_rd_d;
      cyc_wr_q     <= cyc_wr_d;
      cyc_err_q    <= cyc_err_d;
      cycle_type_q <= cycle_type_d;
      error_q      <= error_d;
    end
  end

  sram_array #(.AW(AW), .DW(DW)) u_array (
    .clk   (Clk),
    .rst   (Reset),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (din_prev_q),
    .rdata (ram_rdata)
  );

  // A low WE always takes the bus away from the responder.
  assign DataOE    = (state_q == S_READ) && !ce_q && !oe_q && we_q;
  assign DataOut   = ram_rdata;
  assign CycleDone = (state_q == S_END);
  assign CycleType = cycle_type_q;
  assign Error     = error_q;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: vector table, randomized transactions
// against a memory model, and hand-written error/reset sequences.
module tb_sram_responder;

  logic       Clk, Reset, CE, WE, OE;
  logic [7:0] Addr, DataIn;
  logic [7:0] DataOut;
  logic       DataOE, CycleDone, Error;
  logic [1:0] CycleType;

  int n_cmp = 0;
  int n_bad = 0;

  int         obs_pulses;
  logic [1:0] obs_type;
  logic [7:0] obs_rdata;
  logic       obs_oe_hold, obs_oe_after, obs_oe_bad;

  logic [7:0] ref_mem [256];
  logic [7:0] written [$];

  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
    int         hold;
    logic [1:0] exp_type;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  sram_responder #(.AW(8), .DW(8), .MIN_LOW(2)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .CE        (CE),
    .WE        (WE),
    .OE        (OE),
    .Addr      (Addr),
    .DataIn    (DataIn),
    .DataOut   (DataOut),
    .DataOE    (DataOE),
    .CycleDone (CycleDone),
    .CycleType (CycleType),
    .Error     (Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    Reset = 1'b1; CE = 1'b1; WE = 1'b1; OE = 1'b1;
    step(); step();
    Reset = 1'b0;
    step();
  endtask

  task automatic waitDone();
    obs_pulses = 0;
    obs_type   = 2'b00;
    for (int i = 0; i < 10; i++) begin
      step();
      if (CycleDone) begin
        obs_pulses++;
        obs_type = CycleType;
      end
    end
  endtask

  // kind: 0 = select only, 1 = write, 2 = read
  task automatic applyStimulus(input int kind, input logic [7:0] a, input logic [7:0] d, input int hold);
    obs_oe_bad = 1'b0;
    Addr = a; DataIn = d; CE = 1'b0;
    step();
    if (kind == 1) WE = 1'b0;
    if (kind == 2) OE = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (kind != 2 && DataOE) obs_oe_bad = 1'b1;
    end
    obs_rdata   = DataOut;
    obs_oe_hold = DataOE;
    WE = 1'b1; OE = 1'b1;
    step();
    obs_oe_after = DataOE;
    CE = 1'b1;
    waitDone();
    step();
  endtask

  task automatic runAndCheck(input string label, input int kind, input logic [7:0] a, input logic [7:0] d,
                             input int hold, input logic [1:0] exp_type, input logic [7:0] exp_data);
    applyStimulus(kind, a, d, hold);
    checkOutput({label, "_pulses"}, obs_pulses, 1);
    checkOutput({label, "_type"}, obs_type, exp_type);
    checkOutput({label, "_oe_after"}, obs_oe_after, 0);
    if (kind == 2) begin
      checkOutput({label, "_rdata"}, obs_rdata, exp_data);
      checkOutput({label, "_oe_hold"}, obs_oe_hold, 1);
    end else begin
      checkOutput({label, "_oe_idle"}, obs_oe_bad, 0);
    end
  endtask

  initial begin
    logic       oe_any;
    int         kind, hold;
    logic [7:0] a, d;
    logic [1:0] et;

    Reset = 1'b1; CE = 1'b1; WE = 1'b1; OE = 1'b1; Addr = '0; DataIn = '0;
    doReset();
    checkOutput("rst_dataout", DataOut, 0);
    checkOutput("rst_dataoe", DataOE, 0);
    checkOutput("rst_done", CycleDone, 0);
    checkOutput("rst_type", CycleType, 0);
    checkOutput("rst_error", Error, 0);

    vecs[0] = '{1, 8'h12, 8'hA5, 3, 2'b10, 8'h00};
    vecs[1] = '{2, 8'h12, 8'h00, 3, 2'b01, 8'hA5};
    vecs[2] = '{0, 8'h00, 8'h00, 2, 2'b00, 8'h00};
    vecs[3] = '{1, 8'hFF, 8'h3C, 2, 2'b10, 8'h00};
    vecs[4] = '{2, 8'hFF, 8'h00, 4, 2'b01, 8'h3C};
    vecs[5] = '{1, 8'h00, 8'h01, 4, 2'b10, 8'h00};
    vecs[6] = '{2, 8'h00, 8'h00, 3, 2'b01, 8'h01};
    vecs[7] = '{1, 8'h12, 8'h5A, 2, 2'b10, 8'h00};
    vecs[8] = '{2, 8'h12, 8'h00, 5, 2'b01, 8'h5A};
    vecs[9] = '{2, 8'hFF, 8'h00, 3, 2'b01, 8'h3C};

    for (int i = 0; i < 10; i++) begin
      runAndCheck($sformatf("vec%0d", i), vecs[i].kind, vecs[i].addr, vecs[i].data,
                  vecs[i].hold, vecs[i].exp_type, vecs[i].exp_data);
      if (vecs[i].kind == 1) begin
        ref_mem[vecs[i].addr] = vecs[i].data;
        written.push_back(vecs[i].addr);
      end
    end
    checkOutput("vec_error", Error, 0);

    // Random transactions checked against a plain memory model.
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 2));
      if (kind == 2) begin
        a    = written[$urandom_range(0, written.size() - 1)];
        d    = 8'($urandom);
        hold = int'($urandom_range(3, 5));
        et   = 2'b01;
      end else if (kind == 1) begin
        a    = 8'($urandom);
        d    = 8'($urandom);
        hold = int'($urandom_range(2, 4));
        et   = 2'b10;
      end else begin
        a    = 8'($urandom);
        d    = 8'($urandom);
        hold = int'($urandom_range(1, 3));
        et   = 2'b00;
      end
      runAndCheck($sformatf("rnd%0d", i), kind, a, d, hold, et, ref_mem[a]);
      if (kind == 1) begin
        ref_mem[a] = d;
        written.push_back(a);
      end
    end
    checkOutput("rnd_error", Error, 0);

    // Two writes inside one chip-enable cycle.
    Addr = 8'h60; DataIn = 8'hC1; CE = 1'b0; step();
    WE = 1'b0; step(); step();
    WE = 1'b1; step();
    Addr = 8'h61; DataIn = 8'hC2; step();
    WE = 1'b0; step(); step();
    WE = 1'b1; step();
    CE = 1'b1;
    waitDone();
    step();
    checkOutput("dbl_pulses", obs_pulses, 1);
    checkOutput("dbl_type", obs_type, 2'b10);
    checkOutput("dbl_error", Error, 0);
    runAndCheck("dbl_rd0", 2, 8'h60, 8'h00, 3, 2'b01, 8'hC1);
    runAndCheck("dbl_rd1", 2, 8'h61, 8'h00, 3, 2'b01, 8'hC2);

    // WE and OE low together: write wins, bus never driven, error flagged.
    Addr = 8'h20; DataIn = 8'h99; step();
    oe_any = 1'b0;
    CE = 1'b0; WE = 1'b0; OE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (DataOE) oe_any = 1'b1;
    end
    WE = 1'b1; OE = 1'b1; step();
    if (DataOE) oe_any = 1'b1;
    CE = 1'b1;
    waitDone();
    step();
    checkOutput("conf_oe", oe_any, 0);
    checkOutput("conf_pulses", obs_pulses, 1);
    checkOutput("conf_type", obs_type, 2'b11);
    checkOutput("conf_error", Error, 1);
    runAndCheck("conf_rd", 2, 8'h20, 8'h00, 3, 2'b01, 8'h99);
    checkOutput("conf_sticky", Error, 1);
    doReset();
    checkOutput("conf_rst_error", Error, 0);

    // Address moves while OE is low.
    Addr = 8'h30; CE = 1'b0; step();
    OE = 1'b0; step(); step();
    Addr = 8'h31; step();
    OE = 1'b1; step();
    CE = 1'b1;
    waitDone();
    step();
    checkOutput("glitch_type", obs_type, 2'b11);
    checkOutput("glitch_error", Error, 1);
    runAndCheck("glitch_wr", 1, 8'h32, 8'h44, 2, 2'b10, 8'h00);
    checkOutput("glitch_sticky", Error, 1);
    doReset();
    checkOutput("glitch_rst_error", Error, 0);

    // Reset while a write strobe is still low.
    runAndCheck("rstw_pre", 1, 8'h40, 8'h0F, 2, 2'b10, 8'h00);
    runAndCheck("rstw_rd0", 2, 8'h40, 8'h00, 3, 2'b01, 8'h0F);
    Addr = 8'h40; DataIn = 8'h77; CE = 1'b0; step();
    WE = 1'b0; step(); step(); step();
    Reset = 1'b1; step();
    CE = 1'b1; WE = 1'b1; step(); step();
    Reset = 1'b0; step();
    checkOutput("rstw_dataout", DataOut, 0);
    checkOutput("rstw_dataoe", DataOE, 0);
    checkOutput("rstw_done", CycleDone, 0);
    checkOutput("rstw_type", CycleType, 0);
    checkOutput("rstw_error", Error, 0);
    runAndCheck("rstw_rd1", 2, 8'h40, 8'h00, 3, 2'b01, 8'h0F);

    // One-clock write strobe.
    runAndCheck("short_pre", 1, 8'h50, 8'h22, 2, 2'b10, 8'h00);
    Addr = 8'h50; DataIn = 8'h11; CE = 1'b0; step();
    WE = 1'b0; step();
    WE = 1'b1; step();
    CE = 1'b1;
    waitDone();
    step();
    checkOutput("short_pulses", obs_pulses, 1);
`ifdef TIMING_CHECK_EN
    checkOutput("short_type", obs_type, 2'b11);
    checkOutput("short_error", Error, 1);
    runAndCheck("short_rd", 2, 8'h50, 8'h00, 3, 2'b01, 8'h22);
`else
    checkOutput("short_type", obs_type, 2'b10);
    checkOutput("short_error", Error, 0);
    runAndCheck("short_rd", 2, 8'h50, 8'h00, 3, 2'b01, 8'h11);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
